// File: rtl/sao_pkg.sv
// Shared definitions for the SAO receive path: type codes, FSM states and
// the lcu_size decode.
package sao_pkg;

   localparam int IMG_W = 128;

   localparam logic [1:0] SAO_OFF = 2'd0;
   localparam logic [1:0] SAO_BO  = 2'd1;
   localparam logic [1:0] SAO_EO  = 2'd2;

   typedef enum logic [1:0] {
      ST_RECV,
      ST_DRAIN,
      ST_GAP,
      ST_DONE
   } state_t;

   // Size code 3 is not a legal LCU size and is folded onto 64.
   function automatic logic [6:0] lcu_side(input logic [1:0] code);
      case (code)
         2'd0:    return 7'd16;
         2'd1:    return 7'd32;
         default: return 7'd64;
      endcase
   endfunction

endpackage

// File: rtl/sao_lcu_rx_if.sv
// Pixel-stream, SRAM-write and LCU-completion signals of the SAO receiver.
interface sao_lcu_rx_if #(
   parameter int AW = 14
);
   logic          in_en;
   logic [7:0]    din;
   logic [1:0]    sao_type;
   logic [4:0]    sao_band_pos;
   logic          sao_eo_class;
   logic [15:0]   sao_offset;
   logic [2:0]    lcu_x;
   logic [2:0]    lcu_y;
   logic [1:0]    lcu_size;
   logic          busy;
   logic          finish;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_d;
   logic          lcu_done;
   logic [1:0]    lcu_done_type;
   logic          lcu_done_eo;
   logic [2:0]    lcu_done_x;
   logic [2:0]    lcu_done_y;

   modport master (
      output in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
             lcu_x, lcu_y, lcu_size,
      input  busy, finish, sram_wen, sram_addr, sram_d,
             lcu_done, lcu_done_type, lcu_done_eo, lcu_done_x, lcu_done_y
   );

   modport slave (
      input  in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
             lcu_x, lcu_y, lcu_size,
      output busy, finish, sram_wen, sram_addr, sram_d,
             lcu_done, lcu_done_type, lcu_done_eo, lcu_done_x, lcu_done_y
   );
endinterface

// File: rtl/sao_bo_apply.sv
// Band-offset correction of one pixel: band match against the four bands
// starting at band_pos, then clip to 0..255.
module sao_bo_apply
   import sao_pkg::*;
(
   input  logic [7:0]  din,
   input  logic [4:0]  band_pos,
   input  logic [15:0] offset,
   input  logic [1:0]  sao_type,
   output logic [7:0]  pixel
);

   logic [3:0] offs [4];
   logic [4:0] k;
   logic [3:0] off_sel;
   logic [9:0] sum;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_off
         assign offs[gi] = offset[15-4*gi -: 4];
      end
   endgenerate

   assign k       = din[7:3] - band_pos;
   assign off_sel = offs[k[1:0]];
   // 10-bit two's complement holds -8..262, so bit 9 flags underflow.
   assign sum     = {2'b00, din} + {{6{off_sel[3]}}, off_sel};

   always_comb begin
      pixel = din;
      if (sao_type == SAO_BO && k < 5'd4) begin
         if (sum[9])      pixel = 8'd0;
         else if (sum[8]) pixel = 8'd255;
         else             pixel = sum[7:0];
      end
   end

endmodule

// File: rtl/sao_lcu_rx.sv
// SAO LCU receiver: accepts raster pixels, applies band offset, writes the
// frame SRAM through a two-stage pipeline and reports LCU/frame completion.
module sao_lcu_rx #(
   parameter int IMG_W    = 128,
   parameter int BUSY_GAP = 2,
   parameter int AW       = 14
) (
   input logic         clk,
   input logic         reset,
   sao_lcu_rx_if.slave bus
);
   import sao_pkg::*;

   state_t      state_reg, state_next;
   logic [3:0]  cyc_reg;
   logic [5:0]  col_reg, row_reg;
   logic [6:0]  side_reg;
   logic [1:0]  type_reg;
   logic [4:0]  band_reg;
   logic        eo_reg;
   logic [15:0] off_reg;
   logic [2:0]  x_reg, y_reg;
   logic [7:0]  lcu_cnt_reg, total_reg;
   logic        busy_int;

   logic        s1_valid, s1_last, s1_eo;
   logic [7:0]  s1_din;
   logic [5:0]  s1_row, s1_col;
   logic [6:0]  s1_side;
   logic [1:0]  s1_type;
   logic [4:0]  s1_band;
   logic [15:0] s1_off;
   logic [2:0]  s1_x, s1_y;

   function automatic logic [7:0] lcu_total(input logic [1:0] code);
      case (code)
         2'd0:    return 8'((IMG_W / 16) * (IMG_W / 16));
         2'd1:    return 8'((IMG_W / 32) * (IMG_W / 32));
         default: return 8'((IMG_W / 64) * (IMG_W / 64));
      endcase
   endfunction

   // The first pixel of an LCU uses the live inputs; later pixels the latch.
   logic        accept, first, pix_last;
   logic [6:0]  side_eff, side_m1;
   logic [1:0]  type_eff;
   logic [4:0]  band_eff;
   logic        eo_eff;
   logic [15:0] off_eff;
   logic [2:0]  x_eff, y_eff;

   assign accept   = bus.in_en && !busy_int;
   assign first    = (col_reg == 6'd0) && (row_reg == 6'd0);
   assign side_eff = first ? lcu_side(bus.lcu_size) : side_reg;
   assign type_eff = first ? bus.sao_type     : type_reg;
   assign band_eff = first ? bus.sao_band_pos : band_reg;
   assign eo_eff   = first ? bus.sao_eo_class : eo_reg;
   assign off_eff  = first ? bus.sao_offset   : off_reg;
   assign x_eff    = first ? bus.lcu_x        : x_reg;
   assign y_eff    = first ? bus.lcu_y        : y_reg;
   assign side_m1  = side_eff - 7'd1;
   assign pix_last = accept && ({1'b0, col_reg} == side_m1) && ({1'b0, row_reg} == side_m1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_reg     <= '0;
         row_reg     <= '0;
         side_reg    <= '0;
         type_reg    <= '0;
         band_reg    <= '0;
         eo_reg      <= 1'b0;
         off_reg     <= '0;
         x_reg       <= '0;
         y_reg       <= '0;
         lcu_cnt_reg <= '0;
         total_reg   <= '0;
      end else if (accept) begin
         if (first) begin
            side_reg <= side_eff;
            type_reg <= type_eff;
            band_reg <= band_eff;
            eo_reg   <= eo_eff;
            off_reg  <= off_eff;
            x_reg    <= x_eff;
            y_reg    <= y_eff;
            if (lcu_cnt_reg == 8'd0)
               total_reg <= lcu_total(bus.lcu_size);
         end
         if ({1'b0, col_reg} == side_m1) begin
            col_reg <= '0;
            row_reg <= ({1'b0, row_reg} == side_m1) ? 6'd0 : row_reg + 6'd1;
         end else begin
            col_reg <= col_reg + 6'd1;
         end
         if (pix_last)
            lcu_cnt_reg <= lcu_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_din   <= '0;
         s1_row   <= '0;
         s1_col   <= '0;
         s1_side  <= '0;
         s1_type  <= '0;
         s1_band  <= '0;
         s1_eo    <= 1'b0;
         s1_off   <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
      end else begin
         s1_valid <= accept;
         s1_last  <= pix_last;
         if (accept) begin
            s1_din  <= bus.din;
            s1_row  <= row_reg;
            s1_col  <= col_reg;
            s1_side <= side_eff;
            s1_type <= type_eff;
            s1_band <= band_eff;
            s1_eo   <= eo_eff;
            s1_off  <= off_eff;
            s1_x    <= x_eff;
            s1_y    <= y_eff;
         end
      end
   end

   logic [7:0]    bo_pix;
   logic [AW-1:0] addr_next;

   sao_bo_apply u_bo (
      .din      (s1_din),
      .band_pos (s1_band),
      .offset   (s1_off),
      .sao_type (s1_type),
      .pixel    (bo_pix)
   );

   // Out-of-frame LCU indices simply wrap within the address width.
   assign addr_next = AW'((32'(s1_y) * 32'(s1_side) + 32'(s1_row)) * 32'(IMG_W)
                        + 32'(s1_x) * 32'(s1_side) + 32'(s1_col));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sram_wen      <= 1'b0;
         bus.sram_addr     <= '0;
         bus.sram_d        <= '0;
         bus.lcu_done      <= 1'b0;
         bus.lcu_done_type <= '0;
         bus.lcu_done_eo   <= 1'b0;
         bus.lcu_done_x    <= '0;
         bus.lcu_done_y    <= '0;
      end else begin
         bus.sram_wen <= s1_valid;
         bus.lcu_done <= s1_valid && s1_last;
         if (s1_valid) begin
            bus.sram_addr <= addr_next;
            bus.sram_d    <= bo_pix;
         end
         if (s1_valid && s1_last) begin
            bus.lcu_done_type <= s1_type;
            bus.lcu_done_eo   <= s1_eo;
            bus.lcu_done_x    <= s1_x;
            bus.lcu_done_y    <= s1_y;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_RECV;
         cyc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cyc_reg   <= (state_next != state_reg) ? 4'd0 : cyc_reg + 4'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RECV:  if (pix_last) state_next = ST_DRAIN;
         ST_DRAIN: if (cyc_reg == 4'd1)
                      state_next = (lcu_cnt_reg == total_reg) ? ST_DONE : ST_GAP;
         ST_GAP:   if (cyc_reg == 4'(BUSY_GAP - 1)) state_next = ST_RECV;
         default:  state_next = ST_DONE;
      endcase
   end

   always_comb begin
      busy_int   = (state_reg != ST_RECV);
      bus.finish = (state_reg == ST_DONE);
   end

   assign bus.busy = busy_int;

endmodule

// File: tb/tb_sao_lcu_rx.sv
// Directed bench for sao_lcu_rx: pass-through, band offset, clipping,
// busy handshake, full-frame coverage and mid-LCU reset.
module tb_sao_lcu_rx;
   import sao_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sao_lcu_rx_if #(.AW(14)) bus ();

   sao_lcu_rx #(.IMG_W(128), .BUSY_GAP(2), .AW(14)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passed = 0;
   int wr_cnt = 0, done_cnt = 0, wen_in_reset = 0, finish_early = 0;
   logic [21:0] wq[$];
   logic [7:0]  pix_buf [4096];
   logic [7:0]  exp_mem [16384];
   int          seen [16384];

   always @(negedge clk) begin
      if (bus.sram_wen) begin
         wr_cnt++;
         wq.push_back({bus.sram_addr, bus.sram_d});
         if (reset) wen_in_reset++;
         if (bus.finish) finish_early++;
      end
      if (bus.lcu_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_idle();
      bus.in_en = 1'b0;
      bus.din = '0;
      bus.sao_type = SAO_OFF;
      bus.sao_band_pos = '0;
      bus.sao_eo_class = 1'b0;
      bus.sao_offset = '0;
      bus.lcu_x = '0;
      bus.lcu_y = '0;
      bus.lcu_size = '0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_finish"}, bus.finish, 0);
      check({tag, "_wen"}, bus.sram_wen, 0);
      check({tag, "_addr"}, bus.sram_addr, 0);
      check({tag, "_d"}, bus.sram_d, 0);
      check({tag, "_done"}, bus.lcu_done, 0);
      check({tag, "_dtype"}, {bus.lcu_done_type, bus.lcu_done_eo, bus.lcu_done_x, bus.lcu_done_y}, 0);
   endtask

   // Presents pix_buf[0..n-1]; params are valid on pixel 0 and inverted
   // afterwards so that a failure to latch them shows up.
   task automatic send_lcu(input int n, input logic [1:0] size, input logic [2:0] x,
                           input logic [2:0] y, input logic [1:0] typ, input logic [4:0] bp,
                           input logic eo, input logic [15:0] off);
      int  i;
      int  wait_c;
      bit  tmo;
      bit  acc;
      i = 0; wait_c = 0; tmo = 0;
      while (i < n && !tmo) begin
         @(negedge clk);
         bus.in_en = 1'b1;
         bus.din = pix_buf[i];
         bus.lcu_size     = (i == 0) ? size : ~size;
         bus.lcu_x        = (i == 0) ? x    : ~x;
         bus.lcu_y        = (i == 0) ? y    : ~y;
         bus.sao_type     = (i == 0) ? typ  : ~typ;
         bus.sao_band_pos = (i == 0) ? bp   : ~bp;
         bus.sao_eo_class = (i == 0) ? eo   : ~eo;
         bus.sao_offset   = (i == 0) ? off  : ~off;
         acc = !bus.busy;
         @(posedge clk);
         if (acc) begin
            i++;
            wait_c = 0;
         end else begin
            wait_c++;
            if (wait_c > 50) tmo = 1;
         end
      end
      check("send_timeout", {31'd0, tmo}, 0);
      $display("lcu x=%0d y=%0d size=%0d type=%0d band=%0d off=%h: %0d pixels accepted",
               x, y, size, typ, bp, off, i);
   endtask

   task automatic run_lcu16(input logic [2:0] x, input logic [2:0] y, input logic [1:0] typ,
                            input logic [4:0] bp, input logic eo, input logic [15:0] off);
      wq.delete();
      wr_cnt = 0;
      send_lcu(256, 2'd0, x, y, typ, bp, eo, off);
      #1 set_idle();
      repeat (8) @(negedge clk);
   endtask

   function automatic logic [7:0] wdata(input int idx);
      logic [21:0] e;
      if (idx >= wq.size()) return 8'hxx;
      e = wq[idx];
      return e[7:0];
   endfunction

   function automatic logic [13:0] waddr(input int idx);
      logic [21:0] e;
      if (idx >= wq.size()) return 14'hxxxx;
      e = wq[idx];
      return e[21:8];
   endfunction

   initial begin
      int busy_cycles, err_d, err_a, dup, miss, done_before;
      set_idle();
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      reset = 1'b0;

      // Type 0 ramp at LCU (1,0), 16x16.
      for (int i = 0; i < 256; i++) pix_buf[i] = 8'(i);
      wq.delete(); wr_cnt = 0; done_cnt = 0;
      send_lcu(256, 2'd0, 3'd1, 3'd0, SAO_OFF, 5'd0, 1'b0, 16'h0000);
      #1 set_idle();
      busy_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         else break;
      end
      check("ramp_busy_cycles", busy_cycles, 4);
      check("ramp_writes", wr_cnt, 256);
      check("ramp_first_addr", waddr(0), 16);
      check("ramp_row1_addr", waddr(16), 144);
      check("ramp_last_addr", waddr(255), 15 * 128 + 16 + 15);
      err_d = 0; err_a = 0;
      for (int i = 0; i < 256; i++) begin
         if (wdata(i) !== 8'(i)) err_d++;
         if (waddr(i) !== 14'((i / 16) * 128 + 16 + (i % 16))) err_a++;
      end
      check("ramp_data_errors", err_d, 0);
      check("ramp_addr_errors", err_a, 0);
      check("ramp_done_pulses", done_cnt, 1);
      check("ramp_done_xy", {bus.lcu_done_x, bus.lcu_done_y}, {3'd1, 3'd0});
      check("ramp_finish", bus.finish, 0);

      // Band offset, band_pos=2, offsets +7/-8/+1/0.
      for (int i = 0; i < 256; i++) pix_buf[i] = 8'd0;
      pix_buf[0] = 8'd16; pix_buf[1] = 8'd24; pix_buf[2] = 8'd0;
      pix_buf[3] = 8'd40; pix_buf[4] = 8'd32;
      run_lcu16(3'd2, 3'd1, SAO_BO, 5'd2, 1'b0, 16'h7810);
      check("bo_d16", wdata(0), 23);
      check("bo_d24", wdata(1), 16);
      check("bo_d0", wdata(2), 0);
      check("bo_d40", wdata(3), 40);
      check("bo_d32", wdata(4), 33);
      check("bo_addr0", waddr(0), 2080);
      check("bo_writes", wr_cnt, 256);
      check("bo_done_info", {bus.lcu_done_type, bus.lcu_done_x, bus.lcu_done_y}, {2'd1, 3'd2, 3'd1});

      // Band wrap: band_pos=31, off0=-8.
      pix_buf[0] = 8'd250; pix_buf[1] = 8'd8;
      for (int i = 2; i < 5; i++) pix_buf[i] = 8'd0;
      run_lcu16(3'd3, 3'd1, SAO_BO, 5'd31, 1'b0, 16'h8000);
      check("bo_wrap_d250", wdata(0), 242);
      check("bo_wrap_d8", wdata(1), 8);

      // Clip high: band_pos=31, off0=+7.
      pix_buf[0] = 8'd255; pix_buf[1] = 8'd248; pix_buf[2] = 8'd0;
      run_lcu16(3'd4, 3'd1, SAO_BO, 5'd31, 1'b0, 16'h7000);
      check("clip_hi_d255", wdata(0), 255);
      check("clip_hi_d248", wdata(1), 255);
      check("clip_hi_d0", wdata(2), 0);

      // Clip low: band_pos=0, off0=-8.
      pix_buf[0] = 8'd3; pix_buf[1] = 8'd7; pix_buf[2] = 8'd8;
      run_lcu16(3'd5, 3'd1, SAO_BO, 5'd0, 1'b0, 16'h8000);
      check("clip_lo_d3", wdata(0), 0);
      check("clip_lo_d7", wdata(1), 0);
      check("clip_lo_d8", wdata(2), 8);

      // EO type passes data through and forwards the class.
      pix_buf[0] = 8'd16; pix_buf[1] = 8'd24; pix_buf[2] = 8'd0;
      run_lcu16(3'd6, 3'd1, SAO_EO, 5'd2, 1'b1, 16'h7810);
      check("eo_d16", wdata(0), 16);
      check("eo_d24", wdata(1), 24);
      check("eo_done_info", {bus.lcu_done_type, bus.lcu_done_eo, bus.lcu_done_x, bus.lcu_done_y},
            {2'd2, 1'b1, 3'd6, 3'd1});
      check("eo_finish", bus.finish, 0);

      // Full frame of four 64x64 LCUs with in_en held through the gaps.
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check_zero_outputs("reset2");
      @(negedge clk); reset = 1'b0;
      wq.delete(); wr_cnt = 0; done_cnt = 0; finish_early = 0;
      for (int l = 0; l < 4; l++) begin
         int lx, ly;
         lx = l % 2; ly = l / 2;
         for (int i = 0; i < 4096; i++) begin
            pix_buf[i] = 8'(i * 7 + lx * 3 + ly * 5 + (i >> 6));
            exp_mem[(ly * 64 + i / 64) * 128 + lx * 64 + i % 64] = pix_buf[i];
         end
         send_lcu(4096, 2'd2, 3'(lx), 3'(ly), SAO_OFF, 5'd0, 1'b0, 16'h0000);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.finish) break;
      end
      check("frame_writes", wr_cnt, 16384);
      for (int a = 0; a < 16384; a++) seen[a] = 0;
      err_d = 0;
      for (int i = 0; i < wq.size(); i++) begin
         seen[waddr(i)]++;
         if (wdata(i) !== exp_mem[waddr(i)]) err_d++;
      end
      dup = 0; miss = 0;
      for (int a = 0; a < 16384; a++) begin
         if (seen[a] == 0) miss++;
         if (seen[a] > 1) dup++;
      end
      check("frame_data_errors", err_d, 0);
      check("frame_missing_addr", miss, 0);
      check("frame_dup_addr", dup, 0);
      check("frame_done_pulses", done_cnt, 4);
      check("frame_finish", bus.finish, 1);
      check("frame_busy", bus.busy, 1);
      check("frame_finish_early", finish_early, 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.in_en = 1'b1;
         bus.din = 8'($urandom);
      end
      @(negedge clk);
      check("done_no_writes", wr_cnt, 16384);
      check("done_finish_sticky", bus.finish, 1);
      check("done_busy_sticky", bus.busy, 1);
      set_idle();

      // Reset in the middle of an LCU.
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 256; i++) pix_buf[i] = 8'(i);
      wq.delete(); wr_cnt = 0; done_cnt = 0;
      send_lcu(100, 2'd0, 3'd0, 3'd0, SAO_OFF, 5'd0, 1'b0, 16'h0000);
      #1 reset = 1'b1;
      set_idle();
      @(negedge clk);
      check_zero_outputs("midreset");
      repeat (3) @(negedge clk);
      check("midreset_writes", wr_cnt, 98);
      reset = 1'b0;
      wq.delete(); wr_cnt = 0;
      done_before = done_cnt;
      run_lcu16(3'd0, 3'd0, SAO_OFF, 5'd0, 1'b0, 16'h0000);
      check("restart_writes", wr_cnt, 256);
      check("restart_addr0", waddr(0), 0);
      check("restart_d0", wdata(0), 0);
      check("restart_addr16", waddr(16), 128);
      check("restart_d16", wdata(16), 16);
      check("restart_done", done_cnt - done_before, 1);
      check("wen_during_reset", wen_in_reset, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sao_lcu_rx.md
Name: sao_lcu_rx

Overview:
Receiving end of the SAO pixel-stream interface.
- Accepts raster-order pixels of one LCU at a time under an in_en/busy handshake.
- Latches the per-LCU SAO parameters and applies band offset (BO) inline.
- Writes every pixel to the 128x128 frame SRAM at its frame address and reports LCU completion to the downstream edge-offset (EO) pass.
- Raises finish after the last LCU of the frame has been written.

Parameters:
IMG_W, 128, frame width/height in pixels (square frame)
BUSY_GAP, 2, cycles busy stays high after the last pixel of each LCU
AW, 14, SRAM address width (log2 of IMG_W*IMG_W)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_en  in  1  din and params valid this cycle
din  in  8  pixel, raster order within the LCU
sao_type  in  2  0=off, 1=BO, 2=EO, 3=reserved (treated as off)
sao_band_pos  in  5  first of four BO bands
sao_eo_class  in  1  EO class, forwarded only
sao_offset  in  16  four signed 4-bit offsets, off0=[15:12] .. off3=[3:0]
lcu_x  in  3  LCU column index
lcu_y  in  3  LCU row index
lcu_size  in  2  0=16, 1=32, 2=64 pixels square; 3 treated as 64
busy  out  1  high = sender must not present a pixel
finish  out  1  sticky high after the frame is complete
sram_wen  out  1  one-cycle write strobe
sram_addr  out  AW  frame address = (lcu_y*S+row)*IMG_W + lcu_x*S + col
sram_d  out  8  pixel to write
lcu_done  out  1  one-cycle pulse after the last write of an LCU
lcu_done_type  out  2  latched sao_type of the completed LCU
lcu_done_eo  out  1  latched sao_eo_class of the completed LCU
lcu_done_x, lcu_done_y  out  3 each  indices of the completed LCU

Behaviour:
Reset values: every output is 0, the FSM is in RECV, and all counters are 0.

Parameter capture:
- lcu_size, sao_*, lcu_x and lcu_y are sampled on the first accepted pixel of each LCU (col=0, row=0).
- Those inputs are ignored for the rest of the LCU.

Acceptance and counters:
- A pixel is accepted when in_en=1 and busy=0 at the clock edge.
- in_en while busy=1 is dropped silently and no counter moves.
- col counts 0..S-1, then wraps to 0 and increments row.
- At row=S-1, col=S-1 the LCU is complete.

BO arithmetic:
- band = din[7:3].
- k = (band - band_pos) mod 32.
- If k<4, the result is clip(din + sign-extended off_k, 0, 255), computed at 10-bit signed width.
- In every other case (type 0/2/3, or k>=4) din passes unmodified.

Pipeline (latency 2 from accept to write):
- Stage 1 registers din, row, col and the latched params.
- Stage 2 registers sram_d, sram_addr and sram_wen=1.
- Exactly one write per accepted pixel, in acceptance order, with no bubbles while in_en=1 and busy=0.

FSM:
- RECV: accepting pixels. On the accept of the last pixel of an LCU, go to DRAIN; busy rises the next cycle.
- DRAIN: held for 2 cycles. lcu_done pulses in the same cycle as the final sram_wen.
- GAP: BUSY_GAP cycles, busy held high.
- If the completed LCU was the last of the frame (LCU count = (IMG_W/S)^2), go to DONE instead of GAP. Otherwise return to RECV with busy low.
- DONE: busy=1 and finish=1 permanently until reset; all input is ignored.

Boundary conditions:
- Reset mid-LCU discards pending pipeline writes; no sram_wen is issued after reset asserts.
- lcu_size changing between LCUs takes effect at the next first pixel.
- The LCU count for the frame uses the S latched at the first LCU.
- Out-of-range lcu_x*S >= IMG_W produces truncated addresses, with no error output.

Decomposition:
- Package sao_pkg: the SAO_OFF/SAO_BO/SAO_EO type codes, FSM state enum, lcu_size-to-S decode function, and IMG_W.
- One sub-module, sao_bo_apply: combinational band match plus clip, (din, band_pos, offset, type) -> pixel.

Test Plan:
- Reset, then one 16x16 LCU at (x=1, y=0) with type=0 and din=ramp 0..255 -> 256 writes; the first address is 16, the row-1 start is 128+16=144, data equals din, lcu_done fires once, and busy is high for exactly 4 cycles (2 DRAIN + 2 GAP) afterwards.
- BO with band_pos=2 and offsets +7/-8/+1/0: din=16 -> 23, din=24 -> 16, din=0 -> 0, din=40 -> 40. Repeat with band_pos=31, off0=-8: din=250 -> 242.
- Clip: BO band_pos=31, off0=+7, din=255 -> 255; band_pos=0, off0=-8, din=3 -> 0.
- Handshake: hold in_en=1 continuously through the busy gap -> pixels presented while busy are not written, and the total write count equals 4096 per 64x64 LCU.
- Full frame with lcu_size=2 (four 64x64 LCUs in raster order) -> 16384 writes covering every address once, finish rises after the last write and stays high, and busy stays high.
- Assert reset mid-LCU after 100 pixels -> no further sram_wen, all outputs 0; a fresh LCU afterwards starts at row=0, col=0.
